// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: writeback has priority, MDU results
// are buffered in order and drained on idle cycles, with a busy scoreboard.
module regfile_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_register,
  input  logic [31:0] wb_write_data_reg,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  output logic        busy_rs,
  output logic        busy_rt,
  output logic        reg_write,
  output logic [4:0]  write_register,
  output logic [31:0] write_data_reg,
  output logic        mdu_pending,
  output logic        hold_req
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   sb;
  logic [31:0]   sb_next;
  logic [3:0]    starve;
  logic [3:0]    starve_next;

  logic full;
  logic empty;
  logic wb_grant;
  logic push;
  logic pop;
  logic [4:0] head_reg;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign mdu_ready = !full;
  assign wb_grant  = wb_reg_write && (wb_write_register != 5'd0);
  assign push      = mdu_valid && !full && (mdu_reg != 5'd0);
  assign pop       = !wb_grant && !empty;
  assign head_reg  = fifo_reg[rd_ptr];

  assign mdu_pending = !empty;
  assign busy_rs     = sb[rs_id];
  assign busy_rt     = sb[rt_id];

  // Set after clear so a re-issue in the pop cycle stays busy.
  always_comb begin
    sb_next = sb;
    if (pop) sb_next[head_reg] = 1'b0;
    if (issue_valid && issue_reg != 5'd0) sb_next[issue_reg] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = starve;
    if (empty || pop) starve_next = 4'd0;
    else if (wb_grant && starve != 4'hf) starve_next = starve + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= mdu_reg;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      sb             <= '0;
      starve         <= 4'd0;
      hold_req       <= 1'b0;
      reg_write      <= 1'b0;
      write_register <= 5'd0;
      write_data_reg <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      sb       <= sb_next;
      starve   <= starve_next;
      hold_req <= (starve_next >= 4'(STARVE_LIMIT));
      reg_write <= wb_grant || pop;
      if (wb_grant) begin
        write_register <= wb_write_register;
        write_data_reg <= wb_write_data_reg;
      end else if (pop) begin
        write_register <= head_reg;
        write_data_reg <= fifo_data[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed table-driven bench for regfile_wr_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_write;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data_reg;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        busy_rs;
  logic        busy_rt;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data_reg;
  logic        mdu_pending;
  logic        hold_req;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_reg_write(wb_reg_write),
    .wb_write_register(wb_write_register),
    .wb_write_data_reg(wb_write_data_reg),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rs_id(rs_id), .rt_id(rt_id),
    .busy_rs(busy_rs), .busy_rt(busy_rt),
    .reg_write(reg_write),
    .write_register(write_register),
    .write_data_reg(write_data_reg),
    .mdu_pending(mdu_pending), .hold_req(hold_req)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_rw;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdat;
    logic        e_rdy;
    logic        e_brs;
    logic        e_brt;
    logic        e_pend;
    logic        e_hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic we, input logic [4:0] wr, input logic [31:0] wd,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic iv, input logic [4:0] ir,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic rw, input logic [4:0] wreg, input logic [31:0] wdat,
    input logic rdy, input logic brs, input logic brt,
    input logic pend, input logic hold);
    vec_t t;
    t.we = we; t.wr = wr; t.wd = wd;
    t.mv = mv; t.mr = mr; t.md = md;
    t.iv = iv; t.ir = ir; t.rs = rs; t.rt = rt;
    t.e_rw = rw; t.e_wreg = wreg; t.e_wdat = wdat;
    t.e_rdy = rdy; t.e_brs = brs; t.e_brt = brt;
    t.e_pend = pend; t.e_hold = hold;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    wb_reg_write = t.we; wb_write_register = t.wr; wb_write_data_reg = t.wd;
    mdu_valid = t.mv; mdu_reg = t.mr; mdu_data = t.md;
    issue_valid = t.iv; issue_reg = t.ir; rs_id = t.rs; rt_id = t.rt;
  endtask

  task automatic check_outs(input string tag, input vec_t t);
    chk({tag, "_reg_write"}, 32'(reg_write), 32'(t.e_rw));
    if (t.e_rw) begin
      chk({tag, "_write_register"}, 32'(write_register), 32'(t.e_wreg));
      chk({tag, "_write_data_reg"}, write_data_reg, t.e_wdat);
    end
    chk({tag, "_mdu_ready"}, 32'(mdu_ready), 32'(t.e_rdy));
    chk({tag, "_busy_rs"}, 32'(busy_rs), 32'(t.e_brs));
    chk({tag, "_busy_rt"}, 32'(busy_rt), 32'(t.e_brt));
    chk({tag, "_mdu_pending"}, 32'(mdu_pending), 32'(t.e_pend));
    chk({tag, "_hold_req"}, 32'(hold_req), 32'(t.e_hold));
  endtask

  task automatic step(input string tag, input vec_t t);
    drive(t);
    @(posedge clk);
    #1;
    check_outs(tag, t);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    chk({tag, "_write_register"}, 32'(write_register), 32'd0);
    chk({tag, "_write_data_reg"}, write_data_reg, 32'd0);
    chk({tag, "_mdu_ready"}, 32'(mdu_ready), 32'd1);
    chk({tag, "_busy_rs"}, 32'(busy_rs), 32'd0);
    chk({tag, "_busy_rt"}, 32'(busy_rt), 32'd0);
    chk({tag, "_mdu_pending"}, 32'(mdu_pending), 32'd0);
    chk({tag, "_hold_req"}, 32'(hold_req), 32'd0);
  endtask

  initial begin
    vec_t idle;
    idle = v(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 1,0,0,0,0);
    drive(idle);
    rst = 1'b1;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // we wr wd | mv mr md | iv ir | rs rt || rw wreg wdat | rdy brs brt pend hold
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 0,0,0,        1,0,0,0,0));
    vecs.push_back(v(1,5,32'h1234, 0,0,0,        0,0, 0,0, 1,5,32'h1234, 1,0,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 0,0,0,        1,0,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        1,8, 8,0, 0,0,0,        1,1,0,0,0));
    vecs.push_back(v(0,0,0,        1,8,32'hCAFE, 0,0, 8,0, 0,0,0,        1,1,0,1,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 8,0, 1,8,32'hCAFE, 1,0,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 8,0, 0,0,0,        1,0,0,0,0));
    vecs.push_back(v(1,1,32'h11,   1,3,32'h33,   0,0, 0,0, 1,1,32'h11,   1,0,0,1,0));
    vecs.push_back(v(1,2,32'h22,   1,4,32'h44,   0,0, 0,0, 1,2,32'h22,   0,0,0,1,0));
    vecs.push_back(v(1,1,32'h55,   1,6,32'h66,   0,0, 0,0, 1,1,32'h55,   0,0,0,1,0));
    vecs.push_back(v(1,2,32'h66,   0,0,0,        0,0, 0,0, 1,2,32'h66,   0,0,0,1,0));
    vecs.push_back(v(1,1,32'h77,   0,0,0,        0,0, 0,0, 1,1,32'h77,   0,0,0,1,1));
    vecs.push_back(v(1,2,32'h88,   0,0,0,        0,0, 0,0, 1,2,32'h88,   0,0,0,1,1));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 1,3,32'h33,   1,0,0,1,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 1,4,32'h44,   1,0,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 0,0,0,        1,0,0,0,0));
    vecs.push_back(v(1,0,32'h99,   1,0,32'h98,   0,0, 0,0, 0,0,0,        1,0,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 0,0,0,        1,0,0,0,0));
    vecs.push_back(v(0,0,0,        1,7,32'h77,   0,0, 0,0, 0,0,0,        1,0,0,1,0));
    vecs.push_back(v(1,0,32'h5,    0,0,0,        0,0, 0,0, 1,7,32'h77,   1,0,0,0,0));
    vecs.push_back(v(0,0,0,        1,9,32'h99,   1,9, 0,9, 0,0,0,        1,0,1,1,0));
    vecs.push_back(v(0,0,0,        0,0,0,        1,9, 0,9, 1,9,32'h99,   1,0,1,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,9, 0,0,0,        1,0,1,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        1,0, 0,9, 0,0,0,        1,0,1,0,0));
    vecs.push_back(v(0,0,0,        1,10,32'hA,   0,0, 0,0, 0,0,0,        1,0,0,1,0));
    vecs.push_back(v(0,0,0,        1,11,32'hB,   0,0, 0,0, 1,10,32'hA,   1,0,0,1,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 1,11,32'hB,   1,0,0,0,0));
    vecs.push_back(v(1,1,32'h1,    1,12,32'hC,   0,0, 0,0, 1,1,32'h1,    1,0,0,1,0));
    vecs.push_back(v(1,1,32'h2,    1,13,32'hD,   0,0, 0,0, 1,1,32'h2,    0,0,0,1,0));
    vecs.push_back(v(0,0,0,        1,14,32'hE,   0,0, 0,0, 1,12,32'hC,   1,0,0,1,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 1,13,32'hD,   1,0,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,        0,0, 0,0, 0,0,0,        1,0,0,0,0));

    foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

    // Mid-operation reset with two buffered results and sb[8] set.
    step("mr0", v(0,0,0, 0,0,0, 1,8, 8,0, 0,0,0,      1,1,0,0,0));
    step("mr1", v(1,1,32'h1, 1,20,32'h20, 0,0, 8,0, 1,1,32'h1, 1,1,0,1,0));
    step("mr2", v(1,2,32'h2, 1,21,32'h21, 0,0, 8,0, 1,2,32'h2, 0,1,0,1,0));
    drive(v(1,3,32'h3, 0,0,0, 0,0, 8,0, 0,0,0, 1,0,0,0,0));
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++)
      step($sformatf("post_rst%0d", k),
           v(0,0,0, 0,0,0, 0,0, 8,20, 0,0,0, 1,0,0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
